// File: rtl/snake_pkg.sv
// Shared encodings for the snake move controller: directions, FSM states,
// default grid size and a direction helper.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;

  // Opposite pairs differ only in bit 0 (right/left, up/down).
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-tick divider: counts enabled clk cycles and pulses tick for one cycle
// on count TICK_DIV-1, wrapping back to 0 on that same edge.
module snake_tick_div #(
  parameter int TICK_DIV = 2500000,
  parameter int DIV_W    = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = en && (r_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game-step sequencer: move ticks, direction arbitration, next-head
// computation and req/ack handoff to the body register. Edge wrap: SNAKE_WRAP_EN.
//
// Handshake: shift_req rises the cycle after a legal tick and stays high, with
// head_x/head_y stable, until the cycle shift_ack is sampled high; hit_self and
// hit_food are only meaningful in that ack cycle. shift_req drops the next cycle.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 2500000,
  parameter int DIV_W    = 22,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               shift_ack,
  input  logic               hit_self,
  input  logic               hit_food,
  output logic               shift_req,
  output logic [X_W-1:0]     head_x,
  output logic [Y_W-1:0]     head_y,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         dbg_state
);

  logic [1:0]         r_state;
  logic [1:0]         r_dir;
  logic [1:0]         r_pend;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_grow;
  logic [SCORE_W-1:0] r_score;

  logic               w_tick;
  logic               w_start_game;
  logic [1:0]         w_pend_nxt;
  logic [X_W:0]       w_x_ext;
  logic [Y_W:0]       w_y_ext;
  logic               w_x_off;
  logic               w_y_off;
  logic [X_W-1:0]     w_nx;
  logic [Y_W-1:0]     w_ny;
  logic               w_legal;

  assign w_start_game = start && (r_state == ST_IDLE || r_state == ST_OVER);

  snake_tick_div #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state == ST_RUN),
    .clr  (w_start_game),
    .tick (w_tick)
  );

  // Lowest priority first so higher-priority presses overwrite; presses that
  // reverse the committed direction drop out before priority is applied.
  always_comb begin
    w_pend_nxt = r_pend;
    if (btn_right && (r_dir != dir_opposite(DIR_RIGHT))) w_pend_nxt = DIR_RIGHT;
    if (btn_left  && (r_dir != dir_opposite(DIR_LEFT)))  w_pend_nxt = DIR_LEFT;
    if (btn_down  && (r_dir != dir_opposite(DIR_DOWN)))  w_pend_nxt = DIR_DOWN;
    if (btn_up    && (r_dir != dir_opposite(DIR_UP)))    w_pend_nxt = DIR_UP;
  end

  // One extra bit catches both x+1 == GRID_W and the 0-1 underflow.
  always_comb begin
    w_x_ext = {1'b0, r_x};
    w_y_ext = {1'b0, r_y};
    case (r_pend)
      DIR_RIGHT: w_x_ext = {1'b0, r_x} + (X_W+1)'(1);
      DIR_LEFT:  w_x_ext = {1'b0, r_x} - (X_W+1)'(1);
      DIR_UP:    w_y_ext = {1'b0, r_y} - (Y_W+1)'(1);
      default:   w_y_ext = {1'b0, r_y} + (Y_W+1)'(1);
    endcase
    w_x_off = (w_x_ext >= (X_W+1)'(GRID_W));
    w_y_off = (w_y_ext >= (Y_W+1)'(GRID_H));
`ifdef SNAKE_WRAP_EN
    w_nx    = w_x_off ? ((r_pend == DIR_RIGHT) ? '0 : X_W'(GRID_W - 1)) : w_x_ext[X_W-1:0];
    w_ny    = w_y_off ? ((r_pend == DIR_DOWN)  ? '0 : Y_W'(GRID_H - 1)) : w_y_ext[Y_W-1:0];
    w_legal = 1'b1;
`else
    w_nx    = w_x_ext[X_W-1:0];
    w_ny    = w_y_ext[Y_W-1:0];
    w_legal = !(w_x_off || w_y_off);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_RIGHT;
      r_pend  <= DIR_RIGHT;
      r_x     <= X_W'(GRID_W / 2);
      r_y     <= Y_W'(GRID_H / 2);
      r_grow  <= 1'b0;
      r_score <= '0;
    end else begin
      r_grow <= 1'b0;
      if (r_state != ST_OVER) r_pend <= w_pend_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_tick) begin
            r_dir <= r_pend;
            if (w_legal) begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_OVER;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_ack) begin
            if (hit_self) begin
              r_state <= ST_OVER;
            end else begin
              if (hit_food) begin
                r_grow <= 1'b1;
                if (r_score != '1) r_score <= r_score + SCORE_W'(1);
              end
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          if (start) begin
            r_x     <= X_W'(GRID_W / 2);
            r_y     <= Y_W'(GRID_H / 2);
            r_dir   <= DIR_RIGHT;
            r_pend  <= DIR_RIGHT;
            r_score <= '0;
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign shift_req = (r_state == ST_SHIFT);
  assign game_over = (r_state == ST_OVER);
  assign head_x    = r_x;
  assign head_y    = r_y;
  assign dir       = r_dir;
  assign grow      = r_grow;
  assign score     = r_score;
  assign dbg_state = r_state;

endmodule
